// File: rtl/sccpu_mem_harness.sv
// Instruction/data memory harness for a single-cycle CPU core.
// Adds program loading, address fault flags and access counters.
module sccpu_mem_harness #(
  parameter int          IMEM_DEPTH   = 1024,
  parameter int          DMEM_DEPTH   = 1024,
  parameter logic [31:0] PC_BASE      = 32'h0000_0000,
  parameter logic [31:0] DMEM_BASE    = 32'h0000_0000,
  parameter int          READ_LATENCY = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   pc,
  output logic [31:0]                   inst,
  input  logic [31:0]                   alu,
  input  logic [31:0]                   data,
  input  logic                          d_ram_rena,
  input  logic                          d_ram_wena,
  output logic [31:0]                   mem,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  output logic                          imem_fault,
  output logic                          dmem_fault,
  output logic [31:0]                   cycle_count,
  output logic [15:0]                   load_count,
  output logic [15:0]                   store_count
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];

  logic [29:0]    i_wrd;
  logic [29:0]    d_wrd;
  logic [IAW-1:0] i_idx;
  logic [DAW-1:0] d_idx;
  logic           i_ok;
  logic           d_ok;
  logic           rd_en;
  logic           wr_en;
  logic           d_bad;
  logic [31:0]    mem_d;

  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [15:0] load_cnt_q, load_cnt_d;
  logic [15:0] store_cnt_q, store_cnt_d;
  logic        imem_fault_q, imem_fault_d;
  logic        dmem_fault_q, dmem_fault_d;

  // Word-granular offsets; both bases are word-aligned byte addresses.
  always_comb begin
    i_wrd = pc[31:2] - PC_BASE[31:2];
    d_wrd = alu[31:2] - DMEM_BASE[31:2];
    i_ok  = (pc[1:0] == 2'b00) && (i_wrd < 30'(IMEM_DEPTH));
    d_ok  = (alu[1:0] == 2'b00) && (d_wrd < 30'(DMEM_DEPTH));
    i_idx = i_wrd[IAW-1:0];
    d_idx = d_wrd[DAW-1:0];
    rd_en = d_ok && d_ram_rena && !rst;
    wr_en = d_ok && d_ram_wena && !rst;
    d_bad = !d_ok && (d_ram_rena || d_ram_wena);
    inst  = i_ok ? imem[i_idx] : 32'h0;
    mem_d = rd_en ? dmem[d_idx] : 32'h0;
  end

  // Program loading stays live in reset so images can be preloaded.
  always_ff @(posedge clk) begin
    if (prog_we) imem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (wr_en) dmem[d_idx] <= data;
  end

  always_comb begin
    cycle_cnt_d  = cycle_cnt_q + 32'd1;
    load_cnt_d   = load_cnt_q;
    store_cnt_d  = store_cnt_q;
    imem_fault_d = imem_fault_q || !i_ok;
    dmem_fault_d = dmem_fault_q || d_bad;
    if (rd_en && load_cnt_q != 16'hFFFF)
      load_cnt_d = load_cnt_q + 16'd1;
    if (wr_en && store_cnt_q != 16'hFFFF)
      store_cnt_d = store_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q  <= '0;
      load_cnt_q   <= '0;
      store_cnt_q  <= '0;
      imem_fault_q <= 1'b0;
      dmem_fault_q <= 1'b0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      load_cnt_q   <= load_cnt_d;
      store_cnt_q  <= store_cnt_d;
      imem_fault_q <= imem_fault_d;
      dmem_fault_q <= dmem_fault_d;
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_reg
      logic [31:0] mem_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_q <= '0;
        else     mem_q <= mem_d;
      end
      assign mem = mem_q;
    end else begin : g_comb
      assign mem = mem_d;
    end
  endgenerate

  assign cycle_count = cycle_cnt_q;
  assign load_count  = load_cnt_q;
  assign store_count = store_cnt_q;
  assign imem_fault  = imem_fault_q;
  assign dmem_fault  = dmem_fault_q;

endmodule

// File: tb/tb_sccpu_mem_harness.sv
// Self-checking bench: two harness instances (comb and registered read)
// driven in lockstep and compared against an array-based reference model.
module tb_sccpu_mem_harness;

  localparam int          DEP = 64;
  localparam logic [31:0] PCB = 32'h0000_1000;
  localparam logic [31:0] DB  = 32'h0000_2000;

  logic        clk, rst;
  logic [31:0] pc, alu, data, prog_data;
  logic        rena, wena, prog_we;
  logic [5:0]  prog_addr;

  logic [31:0] inst0, mem0, cc0, inst1, mem1, cc1;
  logic        if0, df0, if1, df1;
  logic [15:0] lc0, sc0, lc1, sc1;

  sccpu_mem_harness #(
    .IMEM_DEPTH(DEP), .DMEM_DEPTH(DEP), .PC_BASE(PCB),
    .DMEM_BASE(DB), .READ_LATENCY(0)
  ) u0 (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst0), .alu(alu),
    .data(data), .d_ram_rena(rena), .d_ram_wena(wena), .mem(mem0),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .imem_fault(if0), .dmem_fault(df0), .cycle_count(cc0),
    .load_count(lc0), .store_count(sc0)
  );

  sccpu_mem_harness #(
    .IMEM_DEPTH(DEP), .DMEM_DEPTH(DEP), .PC_BASE(PCB),
    .DMEM_BASE(DB), .READ_LATENCY(1)
  ) u1 (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst1), .alu(alu),
    .data(data), .d_ram_rena(rena), .d_ram_wena(wena), .mem(mem1),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .imem_fault(if1), .dmem_fault(df1), .cycle_count(cc1),
    .load_count(lc1), .store_count(sc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] im [DEP];
  logic [31:0] dm [DEP];
  int unsigned m_cyc;
  int          m_ld, m_st;
  bit          m_if, m_df;
  logic [31:0] m_mem1;
  logic [31:0] last_inst, last_mem0;

  typedef struct {
    logic [31:0] pc, alu, data;
    bit          ren, wen;
    logic [31:0] e_inst, e_mem;
    int          e_ld, e_st;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit ok_addr(logic [31:0] a, logic [31:0] base);
    longint off;
    off = longint'({32'h0, a}) - longint'({32'h0, base});
    return off >= 0 && off % 4 == 0 && off / 4 < DEP;
  endfunction

  function automatic int idx_of(logic [31:0] a, logic [31:0] base);
    return int'((a - base) / 4);
  endfunction

  function automatic logic [31:0] pick(logic [31:0] base, bit bad_ok);
    logic [31:0] r;
    r = base + 4 * $urandom_range(0, DEP - 1);
    if (bad_ok && $urandom_range(0, 5) == 0) begin
      case ($urandom_range(0, 2))
        0: r = r + $urandom_range(1, 3);
        1: r = base + 4 * DEP + 4 * $urandom_range(0, 1000);
        default: r = base - 32'd4;
      endcase
    end
    return r;
  endfunction

  task automatic chk_state();
    chk("mem_reg", mem1, m_mem1);
    chk("cycle_count", cc0, m_cyc);
    chk("load_count", 32'(lc0), m_ld);
    chk("store_count", 32'(sc0), m_st);
    chk("imem_fault", 32'(if0), 32'(m_if));
    chk("dmem_fault", 32'(df0), 32'(m_df));
  endtask

  // One cycle: drive, check combinational outputs, clock, check state.
  task automatic apply(logic [31:0] p, logic [31:0] a,
                       logic [31:0] d, bit r, bit w);
    bit          iv, dv;
    logic [31:0] e_inst, e_mem;
    iv = ok_addr(p, PCB);
    dv = ok_addr(a, DB);
    pc = p; alu = a; data = d; rena = r; wena = w;
    #1;
    e_inst = iv ? im[idx_of(p, PCB)] : 32'h0;
    e_mem  = (dv && r) ? dm[idx_of(a, DB)] : 32'h0;
    last_inst = inst0;
    last_mem0 = mem0;
    chk("inst", inst0, e_inst);
    chk("inst_l1", inst1, e_inst);
    chk("mem_comb", mem0, e_mem);
    @(posedge clk);
    m_mem1 = e_mem;
    if (dv && w) dm[idx_of(a, DB)] = d;
    if (dv && r && m_ld < 65535) m_ld++;
    if (dv && w && m_st < 65535) m_st++;
    if (!iv) m_if = 1'b1;
    if (!dv && (r || w)) m_df = 1'b1;
    m_cyc++;
    #1;
    chk_state();
  endtask

  task automatic model_reset();
    m_cyc = 0; m_ld = 0; m_st = 0;
    m_if = 1'b0; m_df = 1'b0; m_mem1 = 32'h0;
  endtask

  initial begin
    logic [31:0] w;
    tbl[0] = '{PCB,     DB + 8,  32'hDEADBEEF, 0, 1,
               32'h20010001, 32'h0, 0, 1};
    tbl[1] = '{PCB + 4, DB + 8,  32'h0, 1, 0,
               32'h20020002, 32'hDEADBEEF, 1, 1};
    tbl[2] = '{PCB,     DB + 12, 32'd5, 0, 1,
               32'h20010001, 32'h0, 1, 2};
    tbl[3] = '{PCB + 4, DB + 12, 32'd9, 1, 1,
               32'h20020002, 32'd5, 2, 3};
    tbl[4] = '{PCB,     DB + 12, 32'h0, 1, 0,
               32'h20010001, 32'd9, 3, 3};

    // Reset with enables active and a bad fetch: all must be ignored.
    rst = 1'b1; pc = PCB + 2; alu = DB + 16; data = 32'h1111;
    rena = 1'b1; wena = 1'b1; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0;
    model_reset();
    #1;
    chk_state();
    for (int i = 0; i < DEP; i++) begin
      @(negedge clk);
      w = (i == 0) ? 32'h20010001 : (i == 1) ? 32'h20020002 : $urandom;
      prog_we = 1'b1; prog_addr = 6'(i); prog_data = w; im[i] = w;
    end
    @(negedge clk);
    prog_we = 1'b0; pc = PCB; rena = 1'b0; wena = 1'b0;
    #1;
    chk_state();
    rst = 1'b0;
    #1;
    chk_state();
    @(posedge clk);
    m_cyc = 1;
    #1;
    chk_state();

    for (int i = 0; i < 5; i++) begin
      apply(tbl[i].pc, tbl[i].alu, tbl[i].data, tbl[i].ren, tbl[i].wen);
      chk("tbl_inst", last_inst, tbl[i].e_inst);
      chk("tbl_mem_comb", last_mem0, tbl[i].e_mem);
      chk("tbl_mem_reg", mem1, tbl[i].e_mem);
      chk("tbl_load_count", 32'(lc0), tbl[i].e_ld);
      chk("tbl_store_count", 32'(sc0), tbl[i].e_st);
    end

    for (int i = 0; i < DEP; i++)
      apply(PCB + 4 * i, DB + 4 * i, $urandom, 1'b0, 1'b1);

    for (int i = 0; i < 200; i++)
      apply(pick(PCB, 0), pick(DB, 0), $urandom,
            1'($urandom), 1'($urandom));

    // Misaligned fetch, then misaligned store aliasing word 0.
    apply(PCB + 2, DB, 32'h0, 1'b0, 1'b0);
    chk("bad_fetch_inst", last_inst, 32'h0);
    chk("imem_fault_set", 32'(if0), 32'd1);
    chk("dmem_fault_clear", 32'(df0), 32'd0);
    apply(PCB, DB + 1, 32'hBAD0BAD0, 1'b1, 1'b1);
    chk("bad_load_mem", last_mem0, 32'h0);
    chk("dmem_fault_set", 32'(df0), 32'd1);
    apply(PCB, DB, 32'h0, 1'b1, 1'b0);
    apply(PCB + 4 * DEP, DB + 4 * DEP, 32'h0BAD, 1'b1, 1'b1);

    for (int i = 0; i < 200; i++)
      apply(pick(PCB, 1), pick(DB, 1), $urandom,
            1'($urandom), 1'($urandom));

    force u0.store_cnt_q = 16'hFFFE;
    force u1.store_cnt_q = 16'hFFFE;
    #1;
    release u0.store_cnt_q;
    release u1.store_cnt_q;
    m_st = 65534;
    for (int i = 0; i < 3; i++)
      apply(PCB, DB + 4 * i, $urandom, 1'b0, 1'b1);
    chk("store_sat", 32'(sc0), 32'h0000FFFF);
    chk("store_sat_l1", 32'(sc1), 32'h0000FFFF);

    force u0.cycle_cnt_q = 32'hFFFFFFFF;
    force u1.cycle_cnt_q = 32'hFFFFFFFF;
    #1;
    release u0.cycle_cnt_q;
    release u1.cycle_cnt_q;
    m_cyc = 32'hFFFFFFFF;
    apply(PCB, DB, 32'h0, 1'b0, 1'b0);
    chk("cycle_wrap", cc0, 32'h0);
    chk("cycle_wrap_l1", cc1, 32'h0);

    // Registered read in flight, then reset between edges.
    dm[5] = 32'hC0FFEE01;
    apply(PCB, DB + 20, 32'hC0FFEE01, 1'b0, 1'b1);
    apply(PCB, DB + 20, 32'h0, 1'b1, 1'b0);
    chk("pre_reset_mem", mem1, 32'hC0FFEE01);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk_state();
    chk("async_mem_reg", mem1, 32'h0);
    chk("async_mem_comb", mem0, 32'h0);
    @(posedge clk);
    #1;
    chk_state();
    @(negedge clk);
    rena = 1'b0; pc = PCB;
    rst = 1'b0;
    #1;
    chk("post_rel_mem", mem1, 32'h0);
    chk("post_rel_cycle", cc0, 32'h0);
    @(posedge clk);
    m_cyc = 1;
    #1;
    chk_state();
    for (int i = 0; i < DEP; i++)
      apply(PCB + 4 * i, DB + 4 * i, 32'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sccpu_mem_harness.md
SCCPU_MEM_HARNESS -- requirements
Module: sccpu_mem_harness

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- IMEM_DEPTH, 1024, instruction words; power of two, 16..4096.
- DMEM_DEPTH, 1024, data words; power of two, 16..4096.
- PC_BASE, 32'h00000000, byte address of imem word 0.
- DMEM_BASE, 32'h00000000, byte address of dmem word 0.
- READ_LATENCY, 0, data read latency; 0 = combinational, 1 = registered.
REQ-002 The block SHALL have these ports, one clock, reset asynchronous active-high:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- pc  in  32  CPU fetch byte address.
- inst  out  32  instruction to the CPU.
- alu  in  32  CPU data byte address.
- data  in  32  CPU store data.
- d_ram_rena  in  1  load enable.
- d_ram_wena  in  1  store enable.
- mem  out  32  load data to the CPU.
- prog_we  in  1  imem program write strobe.
- prog_addr  in  log2(IMEM_DEPTH)  imem word index.
- prog_data  in  32  imem program word.
- imem_fault  out  1  sticky bad-fetch flag.
- dmem_fault  out  1  sticky bad-data-access flag.
- cycle_count  out  32  cycles since reset release.
- load_count  out  16  accepted loads, saturating.
- store_count  out  16  accepted stores, saturating.

Function
REQ-003 Fetch index SHALL be (pc - PC_BASE) >> 2; fetch is valid when pc[1:0] = 0 and the index is < IMEM_DEPTH.
REQ-004 inst SHALL be combinational: imem[index] on a valid fetch, otherwise 32'h00000000 (nop).
REQ-005 An invalid fetch while rst = 0 SHALL set imem_fault at the next rising edge; imem_fault stays 1 until reset.
REQ-006 prog_we = 1 SHALL write prog_data into imem[prog_addr] at the rising edge; a same-cycle fetch of that index returns the old word.
REQ-007 The data index SHALL be (alu - DMEM_BASE) >> 2; a data access is valid when alu[1:0] = 0 and the index is < DMEM_DEPTH.
REQ-008 Valid d_ram_wena SHALL write data into dmem[index] at the rising edge and increment store_count, saturating at 16'hFFFF.
REQ-009 Valid d_ram_rena SHALL increment load_count, saturating at 16'hFFFF.
REQ-010 READ_LATENCY = 0: mem SHALL equal dmem[index] combinationally on a valid d_ram_rena, else 32'h0.
REQ-011 READ_LATENCY = 1: at each rising edge the mem register SHALL load dmem[index] on a valid d_ram_rena, else 32'h0.
REQ-012 With d_ram_rena and d_ram_wena both high at the same address, the read SHALL return the pre-write word (read-before-write) and the write SHALL still occur.
REQ-013 An invalid data access (misaligned or out of range) with rena or wena high SHALL:
- suppress the write;
- return mem = 32'h0;
- leave load_count and store_count unchanged;
- set dmem_fault (sticky) at the next rising edge.
REQ-014 cycle_count SHALL increment by 1 at every rising edge while rst = 0, wrapping from 32'hFFFFFFFF to 0.
REQ-015 All enables asserted while rst = 1 SHALL be ignored, except prog_we, which SHALL remain active during reset so programs can be loaded before release.

Reset
REQ-016 While rst = 1, regardless of clk:
- cycle_count, load_count and store_count SHALL be 0;
- imem_fault and dmem_fault SHALL be 0;
- the mem register SHALL be 0.
REQ-017 Reset SHALL NOT clear imem or dmem contents; contents after power-up are undefined.
REQ-018 Reset asserted mid-operation SHALL abort any pending registered read; the first cycle after release sees mem = 0 and cycle_count = 0.

Verification
REQ-019 Program load and fetch:
- stimulus: rst = 1, prog_we writes 32'h20010001 to index 0 and 32'h20020002 to index 1, release rst; pc = PC_BASE, then PC_BASE+4;
- response: inst = 32'h20010001, then 32'h20020002.
REQ-020 Store then load:
- stimulus: alu = DMEM_BASE+8, data = 32'hDEADBEEF, wena for 1 cycle; then rena;
- response: mem = 32'hDEADBEEF (same cycle for latency 0, next edge for latency 1); store_count = 1; load_count = 1.
REQ-021 Simultaneous read and write:
- stimulus: dmem[3] = 5; rena = wena = 1 at DMEM_BASE+12 with data = 9;
- response: mem = 5; a following read returns 9.
REQ-022 Faults:
- stimulus: pc = PC_BASE+2; then alu = DMEM_BASE+1 with wena = 1;
- response: inst = 0; imem_fault = 1; dmem_fault = 1; dmem unchanged; store_count unchanged.
REQ-023 Saturation and wrap:
- stimulus: force store_count = 16'hFFFE, do 3 valid stores; force cycle_count = 32'hFFFFFFFF, one edge;
- response: store_count = 16'hFFFF; cycle_count = 0.
REQ-024 Asynchronous reset:
- stimulus: assert rst between clock edges during a latency-1 read;
- response: counters, flags and mem go to 0 immediately; imem and dmem contents are preserved.
